intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8: number of interrupt sources, 2..32.
REQ-002 Parameter CAUSE_W, default $clog2(NUM_SRC): width of the cause index.
REQ-003 I_clk  in  1: sole clock; all state updates on its rising edge.
REQ-004 I_rst  in  1: reset, synchronous, active-low (0 = reset).
REQ-005 I_irq  in  NUM_SRC: interrupt lines (e.g. timer O_pulse); a 0->1 transition on bit i is one event.
REQ-006 I_mask_we  in  1: mask register write strobe.
REQ-007 I_mask_wdata  in  NUM_SRC: new mask value; bit = 1 enables that source.
REQ-008 I_ack  in  1: CPU accepted the presented interrupt (ISR entry).
REQ-009 I_eoi  in  1: CPU end-of-interrupt (ISR exit).
REQ-010 O_int  out  1: interrupt request to the CPU.
REQ-011 O_cause  out  CAUSE_W: index of the presented or in-service source.
REQ-012 O_pending  out  NUM_SRC: pending register, read-only view.
REQ-013 O_mask  out  NUM_SRC: mask register, read-only view.

Function
REQ-014 Edge detect: per bit, registered copy of I_irq; event_i = I_irq[i] & ~prev[i]; a line held high produces exactly one event.
REQ-015 Pending set: event_i sets pending[i] the following cycle, independent of mask; pending only cleared by acknowledge (REQ-020) or reset.
REQ-016 Active vector = pending & mask; selected source = lowest index set in active (index 0 highest priority).
REQ-017 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-018 IDLE: O_int = 0; if active != 0, register selected index into O_cause and go to REQ next cycle.
REQ-019 REQ: O_int = 1, O_cause held stable; if active becomes 0 (mask write) before I_ack, drop O_int and return to IDLE; a higher-priority arrival does not change O_cause while in REQ.
REQ-020 REQ with I_ack = 1: clear pending[O_cause], go to SERVICE, O_int = 0 from next cycle; latency event -> O_int = 2 cycles minimum.
REQ-021 SERVICE: O_int = 0, O_cause holds in-service index; no nesting; events keep setting pending.
REQ-022 SERVICE with I_eoi = 1: go to IDLE; next request can be raised the cycle after.
REQ-023 I_ack outside REQ and I_eoi outside SERVICE are ignored.
REQ-024 Simultaneous event on bit i and ack-clear of bit i: set wins, pending[i] = 1 (new event not lost).
REQ-025 Mask write: O_mask = I_mask_wdata next cycle; takes effect for selection from that cycle; mask write and event same cycle both apply.
REQ-026 Events while already pending coalesce into one pending bit (no counting).

Reset
REQ-027 While I_rst = 0 at a clock edge: pending = 0, mask = 0, prev I_irq = 0, state = IDLE, O_int = 0, O_cause = 0.
REQ-028 Reset mid-REQ or mid-SERVICE aborts immediately to IDLE; no event recorded during reset cycles.
REQ-029 First cycle after reset: a line already high registers as an event (prev was 0).

Verification
REQ-030 Mask = 0x01, single-cycle pulse on I_irq[0] -> pending = 0x01 next cycle, O_int = 1 with O_cause = 0 one cycle later; I_ack -> pending = 0x00, O_int = 0; I_eoi -> IDLE.
REQ-031 Mask = 0xFF, I_irq[5] and I_irq[2] pulse same cycle -> O_cause = 2 first; after ack+eoi O_cause = 5 presented.
REQ-032 Mask = 0x00, pulse I_irq[3] -> pending = 0x08, O_int stays 0; write mask = 0x08 -> O_int = 1, O_cause = 3 within 2 cycles.
REQ-033 In REQ with O_cause = 4, pulse I_irq[4] in same cycle as I_ack -> pending[4] = 1 after, re-presented cause 4 after I_eoi.
REQ-034 I_irq[1] held high 100 cycles, mask = 0x02 -> exactly one request; after ack+eoi O_int remains 0.
REQ-035 Assert I_rst = 0 while in SERVICE with pending = 0x30 -> next cycle pending = 0, mask = 0, O_int = 0, O_cause = 0; I_eoi ignored.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// intr_ctrl bus: interrupt lines, mask port, CPU ack/eoi and status views.
// master = CPU/system side, slave = controller side.
interface intr_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int CAUSE_W = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0] I_irq;
  logic               I_mask_we;
  logic [NUM_SRC-1:0] I_mask_wdata;
  logic               I_ack;
  logic               I_eoi;
  logic               O_int;
  logic [CAUSE_W-1:0] O_cause;
  logic [NUM_SRC-1:0] O_pending;
  logic [NUM_SRC-1:0] O_mask;

  modport master (
    output I_irq, I_mask_we, I_mask_wdata,
    output I_ack, I_eoi,
    input  O_int, O_cause, O_pending, O_mask
  );

  modport slave (
    input  I_irq, I_mask_we, I_mask_wdata,
    input  I_ack, I_eoi,
    output O_int, O_cause, O_pending, O_mask
  );
endinterface

// File: rtl/intr_ctrl.sv
// Edge-triggered, fixed-priority interrupt controller.
// Lowest active index wins; one request in flight, no nesting.
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int CAUSE_W = $clog2(NUM_SRC)
) (
  input  logic      I_clk,
  input  logic      I_rst,
  intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t             state_q, state_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] ack_clr;
  logic [CAUSE_W-1:0] sel;

  assign evt    = bus.I_irq & ~prev_q;
  assign active = pend_q & mask_q;

  // Priority pick: scan downward so the lowest set index is kept.
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel = CAUSE_W'(i);
    end
  end

  // Request FSM; the ack clears the presented source's pending bit.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (active != '0) begin
          cause_d = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.I_ack) begin
          ack_clr = NUM_SRC'(1) << cause_q;
          state_d = SERVICE;
        end else if (active == '0) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.I_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // New events override a same-cycle ack clear so none is lost.
  always_comb begin
    pend_d = (pend_q & ~ack_clr) | evt;
    mask_d = bus.I_mask_we ? bus.I_mask_wdata : mask_q;
  end

  // State, edge history, pending and mask registers.
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      prev_q  <= bus.I_irq;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.O_int     = (state_q == REQ);
  assign bus.O_cause   = cause_q;
  assign bus.O_pending = pend_q;
  assign bus.O_mask    = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stimulus queues expected outputs
// per cycle; a negedge monitor pops and compares them.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   id = 0;

  typedef struct {
    int         due;
    int         tag;
    logic       o_int;
    logic [2:0] cause;
    logic [7:0] pend;
    logic [7:0] mask;
  } exp_t;

  exp_t q[$];

  intr_ctrl_if #(.NUM_SRC(8)) ifc ();

  intr_ctrl #(.NUM_SRC(8)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (ifc.O_int !== e.o_int || ifc.O_cause !== e.cause ||
          ifc.O_pending !== e.pend || ifc.O_mask !== e.mask) begin
        bad++;
        $display("FAIL step%0d: got int=%b cause=%0d pend=%h mask=%h want int=%b cause=%0d pend=%h mask=%h",
                 e.tag, ifc.O_int, ifc.O_cause, ifc.O_pending, ifc.O_mask,
                 e.o_int, e.cause, e.pend, e.mask);
      end
    end
  end

  task automatic step(
    input logic       r,
    input logic [7:0] irq,
    input logic       we,
    input logic [7:0] wd,
    input logic       ack,
    input logic       eoi,
    input logic       ei,
    input logic [2:0] ec,
    input logic [7:0] ep,
    input logic [7:0] em
  );
    exp_t e;
    rst              = r;
    ifc.I_irq        = irq;
    ifc.I_mask_we    = we;
    ifc.I_mask_wdata = wd;
    ifc.I_ack        = ack;
    ifc.I_eoi        = eoi;
    id++;
    e.due   = cyc + 1;
    e.tag   = id;
    e.o_int = ei;
    e.cause = ec;
    e.pend  = ep;
    e.mask  = em;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    // single source, ack, eoi
    step(1, 8'h00, 1, 8'h01, 0, 0, 0, 0, 8'h00, 8'h01);
    step(1, 8'h01, 0, 8'h00, 0, 0, 0, 0, 8'h01, 8'h01);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 8'h01, 8'h01);
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h01);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h01);
    // simultaneous 5 and 2: priority
    step(1, 8'h00, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 8'hFF);
    step(1, 8'h24, 0, 8'h00, 0, 0, 0, 0, 8'h24, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 2, 8'h24, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 2, 8'h20, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 2, 8'h20, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 5, 8'h20, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 5, 8'h00, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 5, 8'h00, 8'hFF);
    // masked pending, then unmask
    step(1, 8'h00, 1, 8'h00, 0, 0, 0, 5, 8'h00, 8'h00);
    step(1, 8'h08, 0, 8'h00, 0, 0, 0, 5, 8'h08, 8'h00);
    step(1, 8'h00, 0, 8'h00, 0, 0, 0, 5, 8'h08, 8'h00);
    step(1, 8'h00, 1, 8'h08, 0, 0, 0, 5, 8'h08, 8'h08);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 3, 8'h08, 8'h08);
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 3, 8'h00, 8'h08);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 3, 8'h00, 8'h08);
    // event on cause bit in the ack cycle survives
    step(1, 8'h00, 1, 8'h10, 0, 0, 0, 3, 8'h00, 8'h10);
    step(1, 8'h10, 0, 8'h00, 0, 0, 0, 3, 8'h10, 8'h10);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 4, 8'h10, 8'h10);
    step(1, 8'h10, 0, 8'h00, 1, 0, 0, 4, 8'h10, 8'h10);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 4, 8'h10, 8'h10);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 4, 8'h10, 8'h10);
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 4, 8'h00, 8'h10);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 4, 8'h00, 8'h10);
    // mask write with event; cause held; mask-off withdraw
    step(1, 8'h40, 1, 8'hFF, 0, 0, 0, 4, 8'h40, 8'hFF);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 6, 8'h40, 8'hFF);
    step(1, 8'h01, 0, 8'h00, 0, 0, 1, 6, 8'h41, 8'hFF);
    step(1, 8'h00, 1, 8'h00, 0, 0, 1, 6, 8'h41, 8'h00);
    step(1, 8'h00, 0, 8'h00, 0, 0, 0, 6, 8'h41, 8'h00);
    // stray ack / eoi in IDLE ignored
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 6, 8'h41, 8'h00);
    step(1, 8'h00, 0, 8'h00, 0, 1, 0, 6, 8'h41, 8'h00);
    // level held high: exactly one request
    step(1, 8'h02, 1, 8'h02, 0, 0, 0, 6, 8'h43, 8'h02);
    step(1, 8'h02, 0, 8'h00, 0, 0, 1, 1, 8'h43, 8'h02);
    step(1, 8'h02, 0, 8'h00, 1, 0, 0, 1, 8'h41, 8'h02);
    step(1, 8'h02, 0, 8'h00, 0, 1, 0, 1, 8'h41, 8'h02);
    for (int i = 0; i < 96; i++)
      step(1, 8'h02, 0, 8'h00, 0, 0, 0, 1, 8'h41, 8'h02);
    // reach SERVICE, then reset mid-service
    step(1, 8'h00, 1, 8'h10, 0, 0, 0, 1, 8'h41, 8'h10);
    step(1, 8'h30, 0, 8'h00, 0, 0, 0, 1, 8'h71, 8'h10);
    step(1, 8'h00, 0, 8'h00, 0, 0, 1, 4, 8'h71, 8'h10);
    step(1, 8'h00, 0, 8'h00, 1, 0, 0, 4, 8'h61, 8'h10);
    step(0, 8'h04, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00);
    // line high through reset counts as an edge afterwards
    step(1, 8'h04, 0, 8'h00, 0, 1, 0, 0, 8'h04, 8'h00);
    step(1, 8'h04, 0, 8'h00, 0, 0, 0, 0, 8'h04, 8'h00);
    step(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h04, 8'h00);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      total += q.size();
      bad   += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
